// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for the EX stage; owns HI/LO and
// stalls the front of the pipeline while an operation is in flight.
module ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              cancel,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall_req,
  output logic              done
);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] opnd;      // multiplicand for mul, divisor for div
  logic [DATA_W-1:0] acc_hi;    // product high / partial remainder
  logic [DATA_W-1:0] acc_lo;    // multiplier bits / dividend-then-quotient
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;

  logic              is_muldiv_op;
  logic              signed_op;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic              accept;

  assign is_muldiv_op = ~op[2];
  assign signed_op    = ~op[2] & ~op[0];
  assign a_neg        = signed_op & rs_data[DATA_W-1];
  assign b_neg        = signed_op & rt_data[DATA_W-1];
  assign a_abs        = a_neg ? -rs_data : rs_data;
  assign b_abs        = b_neg ? -rt_data : rt_data;
  assign accept       = (state == S_IDLE) && start && !cancel && is_muldiv_op;

  assign busy      = (state != S_IDLE);
  assign stall_req = (start && is_muldiv_op && (state == S_IDLE)) || (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CALC;
      S_CALC:  if (cancel) state_nxt = S_IDLE;
               else if (cnt == LAST_STEP) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W+1:0]   div_diff;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[DATA_W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_q ? -prod : prod;
    // A zero divisor leaves quotient all-ones; the remainder sign fix restores raw rs.
    quo_fix   = (neg_q && !div_zero) ? -acc_lo : acc_lo;
    rem_fix   = neg_r ? -acc_hi : acc_hi;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            acc_hi   <= '0;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (rt_data == '0);
            opnd     <= op[1] ? b_abs : a_abs;
            acc_lo   <= op[1] ? a_abs : b_abs;
          end else if (start && !cancel && op == OP_MTHI) begin
            hi <= rs_data;
          end else if (start && !cancel && op == OP_MTLO) begin
            lo <= rs_data;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[DATA_W+1]) begin
              acc_hi <= div_diff[DATA_W-1:0];
              acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[DATA_W-1:0];
              acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[DATA_W:1];
            acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
          end
        end
        S_FIX: begin
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*DATA_W-1:DATA_W];
              lo <= prod_fix[DATA_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, stall window, signed/unsigned
// results, divide-by-zero, MTHI/MTLO, busy-ignore, cancel and reset.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        cancel;
  logic [31:0] hi, lo;
  logic        busy, stall_req, done;

  int tests = 0;
  int fails = 0;
  int stalls, done_cyc, idle_cyc;

  ex_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
    .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one op at a negedge and watches 45 cycles. Cycle 0 is the issue
  // cycle (before E0); cycle k lies between edges E(k-1) and E(k).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_c, input int cancel_c,
                        output int n_stall, output int d_cyc, output int i_cyc);
    n_stall = 0; d_cyc = -1; i_cyc = -1;
    start = 1'b1; op = o; rs_data = a; rt_data = b; cancel = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (c > 0) begin
        @(negedge clk);
        start   = (c == inj_c);
        op      = 3'd1;
        rs_data = 32'd2;
        rt_data = 32'd3;
        cancel  = (c == cancel_c);
      end
      #1;
      if (stall_req) n_stall++;
      if (done && d_cyc < 0) d_cyc = c;
      if (c > 0 && !busy && i_cyc < 0) i_cyc = c;
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0; cancel = 1'b0;
    #2;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_stall", stall_req, 0);
    check("reset_done", done, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, stalls, done_cyc, idle_cyc);
    check("multu_stall_cycles", stalls, 34);
    check("multu_done_cycle", done_cyc, 34);
    check("multu_idle_cycle", idle_cyc, 34);
    check("multu_done_pulse_ends", done, 0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, -1, -1, stalls, done_cyc, idle_cyc);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, -1, stalls, done_cyc, idle_cyc);
    check("div_neg_done_cycle", done_cyc, 34);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd3, 32'd7, 32'd0, -1, -1, stalls, done_cyc, idle_cyc);
    check("divu_zero_hi", hi, 32'h0000_0007);
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, -1, -1, stalls, done_cyc, idle_cyc);
    check("div_zero_neg_hi", hi, 32'hFFFF_FFF9);
    check("div_zero_neg_lo", lo, 32'hFFFF_FFFF);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, stalls, done_cyc, idle_cyc);
    check("div_wrap_lo", lo, 32'h8000_0000);
    check("div_wrap_hi", hi, 32'h0000_0000);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 3'd4; rs_data = 32'h1234_5678;
    #1;
    check("mthi_no_stall", stall_req, 0);
    @(negedge clk);
    op = 3'd5; rs_data = 32'h9ABC_DEF0;
    #1;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_no_done", done, 0);
    check("mtlo_no_stall", stall_req, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_no_done", done, 0);
    check("mtlo_not_busy", busy, 0);

    // cancel in IDLE suppresses MTHI; reserved op does nothing
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs_data = 32'hDEAD_BEEF; cancel = 1'b1;
    @(negedge clk);
    op = 3'd6; rs_data = 32'h5555_5555; rt_data = 32'h3; cancel = 1'b0;
    #1;
    check("idle_cancel_hi", hi, 32'h1234_5678);
    check("reserved_no_stall", stall_req, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("reserved_not_busy", busy, 0);
    check("reserved_hi", hi, 32'h1234_5678);
    check("reserved_lo", lo, 32'h9ABC_DEF0);

    // second start while busy is ignored
    run_op(3'd3, 32'd100, 32'd7, 5, -1, stalls, done_cyc, idle_cyc);
    check("ignore_stall_cycles", stalls, 34);
    check("ignore_done_cycle", done_cyc, 34);
    check("ignore_hi", hi, 32'd2);
    check("ignore_lo", lo, 32'd14);

    // cancel mid-calculation
    run_op(3'd1, 32'd3, 32'd4, -1, 10, stalls, done_cyc, idle_cyc);
    check("cancel_idle_cycle", idle_cyc, 11);
    check("cancel_no_done", done_cyc, -1);
    check("cancel_stall_cycles", stalls, 11);
    check("cancel_hi", hi, 32'd2);
    check("cancel_lo", lo, 32'd14);

    // asynchronous reset mid-operation
    start = 1'b1; op = 3'd1; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_busy", busy, 0);
    check("midreset_stall", stall_req, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("post_reset_hi", hi, 0);
    check("post_reset_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage. Consumes operands from the ID/EX pipeline register and owns the HI/LO architectural registers.
- While an operation is in flight, it drives the stall request that feeds the ID/EX hold input, so the pipeline freezes until the result lands.
- Result value is 64-bit: HI = upper word / remainder, LO = lower word / quotient.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  operation request valid this cycle (from EX decode).
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7 reserved (treated as no-op).
- rs_data  in  DATA_W  operand A (multiplicand / dividend / MTHI-MTLO source).
- rt_data  in  DATA_W  operand B (multiplier / divisor).
- cancel  in  1  flush from branch/exception; aborts the in-flight operation.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.
- busy  out  1  operation in flight (state != IDLE).
- stall_req  out  1  hold request to the ID/EX and IF/ID registers.
- done  out  1  one-cycle pulse: HI/LO were updated by a mul/div.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, hi=0, lo=0, done=0, internal accumulators=0. Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - start with op 0-3: latch |A|, |B| and result signs (signed ops only), clear accumulator, go to CALC.
  - start with op 4 (MTHI): write hi=rs_data at the same edge, stay in IDLE, no done, no stall.
  - start with op 5 (MTLO): write lo=rs_data likewise.
  - start with reserved op: no-op.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add over the 64-bit product.
  - Divide: restoring shift-subtract.
  - After the 32nd step (counter reaches DATA_W-1), go to FIX.
- FIX:
  - Negate quotient/product if the result sign is set; negate remainder if the dividend was negative (remainder takes the dividend's sign).
  - Write hi/lo, go to IDLE, set done=1 for the following cycle.
- Latency: start sampled at edge E0; hi/lo updated at E33; done=1 during the cycle after E33.
- stall_req = (start & op<=3 & state==IDLE) | (state==CALC) | (state==FIX). It is combinational, so the instruction issuing the op holds in EX from its first cycle. It drops in the done cycle.
- busy = (state != IDLE).
- start while busy: ignored; operands are not re-latched.
- cancel:
  - In CALC/FIX: state goes to IDLE at the next edge, hi/lo unchanged, no done.
  - In IDLE: suppresses that cycle's start, including MTHI/MTLO writes.
  - cancel has priority over start.
- Divide by zero: no trap. Result is hi=rs_data (raw), lo=all-ones, for both DIV and DIVU; the sign fix is skipped.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no trap).
- Arithmetic is modulo 2^64 in the 64-bit product path; all negations are two's complement at DATA_W.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> stall_req high for 34 cycles starting with the start cycle; done pulse in the cycle after E33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/0 -> hi=0x00000007, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> each visible the next cycle; stall_req=0, done=0 throughout.
- Start DIVU 100/7 and issue a second start (MULTU 2×3) at cycle 5 -> second start ignored; result hi=2, lo=14.
- Start MULTU, assert cancel at cycle 10 -> IDLE next cycle, hi/lo keep prior values, no done. Separately, rst=0 at cycle 10 -> hi=lo=0, busy=stall_req=0 immediately.
